// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified memory port arbiter.
package mem_port_arbiter_pkg;

    // Sequencer states for one memory access
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Which requester currently owns (or last owned) the port
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_t;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-requester round-robin picker: on a tie the requester that did not
// own the port last time wins.
module arb_rr2
    import mem_port_arbiter_pkg::*;
(
    input  logic   req_cpu,
    input  logic   req_ldr,
    input  owner_t last_owner,
    output owner_t gnt_owner,
    output logic   gnt_valid
);

    // Pick a winner; ties go to whoever was not served last
    always_comb begin
        gnt_owner = OWN_CPU;
        gnt_valid = req_cpu | req_ldr;
        if (req_cpu && req_ldr) begin
            gnt_owner = (last_owner == OWN_CPU) ? OWN_LDR : OWN_CPU;
        end else if (req_ldr) begin
            gnt_owner = OWN_LDR;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences the single memory port of the multi-cycle core between the CPU
// control path and the loader/debug port, one registered access at a time.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW  = DEF_AW,
    parameter int DW  = DEF_DW,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_done,
    output logic [DW-1:0] ldr_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(LAT) + 1;

    state_t          state;
    state_t          state_next;
    owner_t          owner;
    owner_t          last_owner;
    owner_t          pick_owner;
    logic            pick_valid;
    logic            cpu_req;
    logic            lat_we;
    logic [AW-1:0]   lat_addr;
    logic [DW-1:0]   lat_wdata;
    logic [CW-1:0]   cnt;
    logic            cnt_zero;

    assign cpu_req  = cpu_rd | cpu_wr;
    assign cnt_zero = (cnt == '0);

    arb_rr2 u_arb (
        .req_cpu    (cpu_req),
        .req_ldr    (ldr_req),
        .last_owner (last_owner),
        .gnt_owner  (pick_owner),
        .gnt_valid  (pick_valid)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: capture in IDLE, count down in ACCESS, single RESP cycle
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (pick_valid) state_next = ST_ACCESS;
            ST_ACCESS: if (cnt_zero)   state_next = ST_RESP;
            ST_RESP:                   state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; gnt is masked during reset so no phantom pulse
    always_comb begin
        mem_en    = (state == ST_ACCESS);
        mem_we    = (state == ST_ACCESS) && lat_we;
        ldr_gnt   = !rst && (state == ST_IDLE) && pick_valid && (pick_owner == OWN_LDR);
        ldr_done  = (state == ST_RESP) && (owner == OWN_LDR);
        cpu_stall = cpu_req && !((state == ST_RESP) && (owner == OWN_CPU));
    end

    // Access latches, latency counter, read-data registers and round-robin history
    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= OWN_CPU;
            last_owner <= OWN_LDR;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= '0;
            cpu_rdata  <= '0;
            ldr_rdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner <= pick_owner;
                        cnt   <= CW'(LAT - 1);
                        if (pick_owner == OWN_CPU) begin
                            lat_we    <= cpu_wr;
                            lat_addr  <= cpu_addr;
                            lat_wdata <= cpu_wdata;
                        end else begin
                            lat_we    <= ldr_we;
                            lat_addr  <= ldr_addr;
                            lat_wdata <= ldr_wdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt_zero) begin
                        if (!lat_we) begin
                            if (owner == OWN_CPU) begin
                                cpu_rdata <= mem_rdata;
                            end else begin
                                ldr_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_RESP: begin
                    last_owner <= owner;
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LAT=2 main instance plus a LAT=1 build.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic        cpu_rd, cpu_wr, ldr_req, ldr_we;
    logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata, mem_rdata;
    logic [31:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata;
    logic        cpu_stall, ldr_gnt, ldr_done, mem_en, mem_we;

    logic        b_cpu_rd;
    logic [31:0] b_cpu_addr, b_mem_rdata;
    logic [31:0] b_cpu_rdata, b_ldr_rdata, b_mem_addr, b_mem_wdata;
    logic        b_cpu_stall, b_ldr_gnt, b_ldr_done, b_mem_en, b_mem_we;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(2)) dut (
        .clk(clk), .rst(rst),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_done(ldr_done), .ldr_rdata(ldr_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .cpu_rd(b_cpu_rd), .cpu_wr(1'b0), .cpu_addr(b_cpu_addr), .cpu_wdata(32'h0),
        .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(32'h0), .ldr_wdata(32'h0),
        .ldr_gnt(b_ldr_gnt), .ldr_done(b_ldr_done), .ldr_rdata(b_ldr_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge (start of the next cycle)
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive the CPU request fields
    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    // Drive the loader request fields
    task automatic applyLoader(input logic req, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata);
        ldr_req   = req;
        ldr_we    = we;
        ldr_addr  = addr;
        ldr_wdata = wdata;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 32'h0, 32'h0);
        applyLoader(0, 0, 32'h0, 32'h0);
        mem_rdata   = 32'h0;
        b_cpu_rd    = 1'b0;
        b_cpu_addr  = 32'h0;
        b_mem_rdata = 32'h0;

        // ---------------- reset state
        nextCycle();
        nextCycle();
        #1;
        checkOutput("rst_mem_en",    32'(mem_en),    32'h0);
        checkOutput("rst_mem_we",    32'(mem_we),    32'h0);
        checkOutput("rst_mem_addr",  mem_addr,       32'h0);
        checkOutput("rst_mem_wdata", mem_wdata,      32'h0);
        checkOutput("rst_cpu_rdata", cpu_rdata,      32'h0);
        checkOutput("rst_ldr_rdata", ldr_rdata,      32'h0);
        checkOutput("rst_ldr_gnt",   32'(ldr_gnt),   32'h0);
        checkOutput("rst_ldr_done",  32'(ldr_done),  32'h0);
        checkOutput("rst_cpu_stall", 32'(cpu_stall), 32'h0);
        rst = 1'b0;

        // ---------------- CPU read alone, addr 0x40
        nextCycle();                                   // cycle 0
        applyStimulus(1, 0, 32'h40, 32'h0);
        #1;
        checkOutput("rd_c0_stall", 32'(cpu_stall), 32'h1);
        checkOutput("rd_c0_en",    32'(mem_en),    32'h0);
        nextCycle();                                   // cycle 1
        cpu_addr  = 32'hFFFC;
        mem_rdata = 32'hBAD0BAD0;
        #1;
        checkOutput("rd_c1_en",    32'(mem_en),    32'h1);
        checkOutput("rd_c1_we",    32'(mem_we),    32'h0);
        checkOutput("rd_c1_addr",  mem_addr,       32'h40);
        checkOutput("rd_c1_stall", 32'(cpu_stall), 32'h1);
        nextCycle();                                   // cycle 2
        mem_rdata = 32'h8C220004;
        #1;
        checkOutput("rd_c2_en",    32'(mem_en),    32'h1);
        checkOutput("rd_c2_addr",  mem_addr,       32'h40);
        checkOutput("rd_c2_stall", 32'(cpu_stall), 32'h1);
        nextCycle();                                   // cycle 3 (RESP)
        #1;
        checkOutput("rd_c3_en",    32'(mem_en),    32'h0);
        checkOutput("rd_c3_stall", 32'(cpu_stall), 32'h0);
        checkOutput("rd_c3_rdata", cpu_rdata,      32'h8C220004);
        applyStimulus(0, 0, 32'h0, 32'h0);

        // ---------------- loader write 0x100 <- 0xDEADBEEF
        nextCycle();                                   // cycle 0 (IDLE)
        applyLoader(1, 1, 32'h100, 32'hDEADBEEF);
        #1;
        checkOutput("lw_c0_gnt",   32'(ldr_gnt),   32'h1);
        nextCycle();                                   // cycle 1
        #1;
        checkOutput("lw_c1_gnt",   32'(ldr_gnt),   32'h0);
        checkOutput("lw_c1_we",    32'(mem_we),    32'h1);
        checkOutput("lw_c1_addr",  mem_addr,       32'h100);
        checkOutput("lw_c1_wdata", mem_wdata,      32'hDEADBEEF);
        nextCycle();                                   // cycle 2
        #1;
        checkOutput("lw_c2_we",    32'(mem_we),    32'h1);
        checkOutput("lw_c2_done",  32'(ldr_done),  32'h0);
        nextCycle();                                   // cycle 3 (RESP)
        #1;
        checkOutput("lw_c3_done",  32'(ldr_done),  32'h1);
        checkOutput("lw_c3_en",    32'(mem_en),    32'h0);
        checkOutput("lw_c3_rdata", ldr_rdata,      32'h0);
        applyLoader(0, 0, 32'h0, 32'h0);

        // ---------------- contention: last owner is LDR, so CPU first
        nextCycle();                                   // cycle 0
        applyStimulus(1, 0, 32'h44, 32'h0);
        applyLoader(1, 0, 32'h200, 32'h0);
        #1;
        checkOutput("ct_c0_gnt",   32'(ldr_gnt),   32'h0);
        nextCycle();                                   // cycle 1
        #1;
        checkOutput("ct_c1_addr",  mem_addr,       32'h44);
        nextCycle();                                   // cycle 2
        mem_rdata = 32'h11111111;
        nextCycle();                                   // cycle 3 (CPU RESP)
        #1;
        checkOutput("ct_c3_stall", 32'(cpu_stall), 32'h0);
        checkOutput("ct_c3_rdata", cpu_rdata,      32'h11111111);
        checkOutput("ct_c3_done",  32'(ldr_done),  32'h0);
        nextCycle();                                   // cycle 4 (IDLE, LDR wins)
        #1;
        checkOutput("ct_c4_gnt",   32'(ldr_gnt),   32'h1);
        checkOutput("ct_c4_stall", 32'(cpu_stall), 32'h1);
        nextCycle();                                   // cycle 5
        #1;
        checkOutput("ct_c5_addr",  mem_addr,       32'h200);
        nextCycle();                                   // cycle 6
        mem_rdata = 32'h22222222;
        nextCycle();                                   // cycle 7 (LDR RESP)
        #1;
        checkOutput("ct_c7_done",  32'(ldr_done),  32'h1);
        checkOutput("ct_c7_lrd",   ldr_rdata,      32'h22222222);
        checkOutput("ct_c7_crd",   cpu_rdata,      32'h11111111);
        checkOutput("ct_c7_stall", 32'(cpu_stall), 32'h1);
        nextCycle();                                   // cycle 8 (IDLE, CPU wins)
        #1;
        checkOutput("ct_c8_gnt",   32'(ldr_gnt),   32'h0);
        nextCycle();                                   // cycle 9
        #1;
        checkOutput("ct_c9_addr",  mem_addr,       32'h44);
        nextCycle();                                   // cycle 10
        mem_rdata = 32'h44444444;
        nextCycle();                                   // cycle 11 (CPU RESP)
        #1;
        checkOutput("ct_c11_stall", 32'(cpu_stall), 32'h0);
        checkOutput("ct_c11_crd",   cpu_rdata,      32'h44444444);
        checkOutput("ct_c11_lrd",   ldr_rdata,      32'h22222222);
        nextCycle();                                   // cycle 12 (IDLE, LDR wins)
        #1;
        checkOutput("ct_c12_gnt",   32'(ldr_gnt),   32'h1);
        applyStimulus(0, 0, 32'h0, 32'h0);
        nextCycle();                                   // cycle 13
        nextCycle();                                   // cycle 14
        mem_rdata = 32'h33333333;
        nextCycle();                                   // cycle 15 (LDR RESP)
        #1;
        checkOutput("ct_c15_done",  32'(ldr_done),  32'h1);
        checkOutput("ct_c15_lrd",   ldr_rdata,      32'h33333333);
        applyLoader(0, 0, 32'h0, 32'h0);

        // ---------------- CPU sw then immediate fetch
        nextCycle();                                   // cycle 0
        applyStimulus(0, 1, 32'h80, 32'hCAFEF00D);
        #1;
        checkOutput("sw_c0_stall", 32'(cpu_stall), 32'h1);
        nextCycle();                                   // cycle 1
        #1;
        checkOutput("sw_c1_we",    32'(mem_we),    32'h1);
        checkOutput("sw_c1_addr",  mem_addr,       32'h80);
        checkOutput("sw_c1_wdata", mem_wdata,      32'hCAFEF00D);
        nextCycle();                                   // cycle 2
        mem_rdata = 32'h77777777;
        #1;
        checkOutput("sw_c2_stall", 32'(cpu_stall), 32'h1);
        nextCycle();                                   // cycle 3 (RESP)
        #1;
        checkOutput("sw_c3_stall", 32'(cpu_stall), 32'h0);
        checkOutput("sw_c3_rdata", cpu_rdata,      32'h44444444);
        applyStimulus(1, 0, 32'h04, 32'h0);
        #1;
        checkOutput("sw_c3_stall2", 32'(cpu_stall), 32'h0);
        nextCycle();                                   // cycle 4 (IDLE, fetch seen)
        #1;
        checkOutput("f_c4_stall",  32'(cpu_stall), 32'h1);
        checkOutput("f_c4_en",     32'(mem_en),    32'h0);
        nextCycle();                                   // cycle 5
        #1;
        checkOutput("f_c5_en",     32'(mem_en),    32'h1);
        checkOutput("f_c5_we",     32'(mem_we),    32'h0);
        checkOutput("f_c5_addr",   mem_addr,       32'h04);
        nextCycle();                                   // cycle 6
        mem_rdata = 32'h12345678;
        #1;
        checkOutput("f_c6_stall",  32'(cpu_stall), 32'h1);
        nextCycle();                                   // cycle 7 (RESP)
        #1;
        checkOutput("f_c7_stall",  32'(cpu_stall), 32'h0);
        checkOutput("f_c7_rdata",  cpu_rdata,      32'h12345678);
        applyStimulus(0, 0, 32'h0, 32'h0);

        // ---------------- reset during loader read ACCESS
        nextCycle();                                   // cycle 0
        applyLoader(1, 0, 32'h300, 32'h0);
        #1;
        checkOutput("rr_c0_gnt",   32'(ldr_gnt),   32'h1);
        nextCycle();                                   // cycle 1 (ACCESS)
        #1;
        checkOutput("rr_c1_en",    32'(mem_en),    32'h1);
        rst = 1'b1;
        nextCycle();                                   // cycle 2 (IDLE after reset)
        #1;
        checkOutput("rr_c2_en",    32'(mem_en),    32'h0);
        checkOutput("rr_c2_done",  32'(ldr_done),  32'h0);
        checkOutput("rr_c2_addr",  mem_addr,       32'h0);
        checkOutput("rr_c2_crd",   cpu_rdata,      32'h0);
        rst = 1'b0;
        #1;
        checkOutput("rr_c2_gnt",   32'(ldr_gnt),   32'h1);
        nextCycle();                                   // cycle 3
        #1;
        checkOutput("rr_c3_done",  32'(ldr_done),  32'h0);
        checkOutput("rr_c3_addr",  mem_addr,       32'h300);
        nextCycle();                                   // cycle 4
        mem_rdata = 32'hA5A5A5A5;
        nextCycle();                                   // cycle 5 (RESP)
        #1;
        checkOutput("rr_c5_done",  32'(ldr_done),  32'h1);
        checkOutput("rr_c5_lrd",   ldr_rdata,      32'hA5A5A5A5);
        applyLoader(0, 0, 32'h0, 32'h0);

        // ---------------- LAT=1 build: CPU read
        nextCycle();                                   // cycle 0
        b_cpu_rd   = 1'b1;
        b_cpu_addr = 32'h8;
        #1;
        checkOutput("l1_c0_stall", 32'(b_cpu_stall), 32'h1);
        checkOutput("l1_c0_en",    32'(b_mem_en),    32'h0);
        nextCycle();                                   // cycle 1
        b_mem_rdata = 32'h0BADCAFE;
        #1;
        checkOutput("l1_c1_en",    32'(b_mem_en),    32'h1);
        checkOutput("l1_c1_addr",  b_mem_addr,       32'h8);
        checkOutput("l1_c1_stall", 32'(b_cpu_stall), 32'h1);
        nextCycle();                                   // cycle 2 (RESP)
        #1;
        checkOutput("l1_c2_en",    32'(b_mem_en),    32'h0);
        checkOutput("l1_c2_stall", 32'(b_cpu_stall), 32'h0);
        checkOutput("l1_c2_rdata", b_cpu_rdata,      32'h0BADCAFE);
        b_cpu_rd = 1'b0;

        nextCycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the single unified memory port of the multi-cycle MIPS core and shares it between two requesters: the CPU control path (fetch and load/store states) and a program loader/debug port. It registers one access at a time, holds the memory enables for a fixed latency, returns read data, and stalls the CPU state register until the CPU's access completes. It sits between the control unit/datapath address mux and the memory macro.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `LAT`, 2, memory access cycles (≥1); read data valid in last access cycle

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `cpu_rd`  in  1  CPU read request (MemRd), level
- `cpu_wr`  in  1  CPU write request (MemWr), level; `cpu_rd`/`cpu_wr` never both high
- `cpu_addr`  in  AW  CPU address (IorD-muxed)
- `cpu_wdata`  in  DW  CPU write data
- `cpu_rdata`  out  DW  registered read data for CPU
- `cpu_stall`  out  1  hold CU state/write enables
- `ldr_req`  in  1  loader request, level, held until `ldr_done`
- `ldr_we`  in  1  loader write when 1, read when 0
- `ldr_addr`  in  AW  loader address
- `ldr_wdata`  in  DW  loader write data
- `ldr_gnt`  out  1  one-cycle pulse: loader request captured
- `ldr_done`  out  1  one-cycle pulse: loader access complete
- `ldr_rdata`  out  DW  registered read data for loader
- `mem_en`  out  1  memory enable
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data

## Operation
- States: IDLE, ACCESS, RESP. Owner register: CPU or LDR. Last-owner register for round-robin.
- IDLE: if exactly one requester active, capture it; if both, grant the one that is not last owner. Capture = latch addr, wdata, we, owner; load counter with LAT-1; go ACCESS. Loader capture pulses `ldr_gnt` in that IDLE cycle.
- ACCESS: `mem_en`=1, `mem_we`=latched we, addr/wdata from latches. Counter decrements each cycle; at counter=0 latch `mem_rdata` into owner's rdata register (reads only), go RESP.
- RESP: `mem_en`=0; owner=LDR pulses `ldr_done`; update last owner; go IDLE.
- `cpu_stall` (combinational) = (`cpu_rd`|`cpu_wr`) & !(state==RESP & owner==CPU). CPU advances on the RESP edge, so back-to-back CPU requests (e.g. sw state then fetch) are each seen as new requests in IDLE.
- Request inputs are ignored outside IDLE; changes to CPU addr/data during ACCESS have no effect.
- `cpu_rdata`/`ldr_rdata` hold value until the next read by the same owner; writes leave them unchanged.

## Timing
- Request first seen in IDLE cycle 0 with port free: `mem_en` high cycles 1..LAT, RESP at cycle LAT+1; `cpu_stall` high cycles 0..LAT, low in LAT+1; `cpu_rdata` valid from cycle LAT+1. Access occupancy LAT+2 cycles, reads and writes identical.
- Contention: losing requester waits for winner's RESP plus return to IDLE, then wins (round-robin alternates under continuous contention).
- Reset values: state IDLE, owner CPU, last owner LDR (CPU wins first tie), `mem_en`=`mem_we`=0, `mem_addr`=`mem_wdata`=0, `cpu_rdata`=`ldr_rdata`=0, `ldr_gnt`=`ldr_done`=0; `cpu_stall` follows its equation.
- Reset mid-access: returns to IDLE next cycle, `mem_en` drops, no `ldr_done`, in-flight access discarded; requesters re-request (CPU levels persist naturally).
- LAT=1: ACCESS lasts exactly one cycle.

## Structure
- Shared package: state encoding (IDLE/ACCESS/RESP), owner encoding (OWN_CPU/OWN_LDR), default AW/DW.
- One sub-module: `arb_rr2` — two-requester round-robin picker (inputs: two requests, last owner; output: grant owner, valid).
- Counter width `$clog2(LAT)+1`.

## Test plan
- CPU read alone, LAT=2, addr 0x40, `mem_rdata`=0x8C220004 in cycle 2 -> `mem_en` cycles 1–2, `cpu_stall` high cycles 0–2, `cpu_rdata`=0x8C220004 in cycle 3.
- Loader write addr 0x100 data 0xDEADBEEF -> `ldr_gnt` cycle 0, `mem_we`=1 cycles 1–2, `ldr_done` cycle 3, `ldr_rdata` unchanged.
- Simultaneous CPU read and loader request after reset -> CPU served first, loader `ldr_gnt` in first IDLE after CPU RESP; repeat contention -> strict alternation.
- CPU sw then immediate fetch (write then read request, consecutive) -> two separate LAT+2 accesses, stall drops exactly once per access in RESP.
- Reset asserted in ACCESS of loader read -> next cycle IDLE, `mem_en`=0, no `ldr_done`; loader re-request completes normally.
- LAT=1 build: CPU read -> `mem_en` cycle 1 only, `cpu_stall` low in cycle 2.
